// File: rtl/alu_sequencer.sv
// Request-side controller for the 8-bit combinational ALU: registers operands,
// waits SETTLE edges, samples the result and returns it with tag, zero flag and error code.
module alu_sequencer #(
  parameter int TAG_W  = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [7:0]       req_op,
  input  logic [7:0]       req_a,
  input  logic [7:0]       req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [7:0]       alu_op,
  input  logic [7:0]       alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_zero,
  output logic [1:0]       rsp_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_DIV0    = 2'b10;

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [1:0]       err_pend_q, err_pend_d;
  logic [7:0]       alu_a_q, alu_a_d;
  logic [7:0]       alu_b_q, alu_b_d;
  logic [7:0]       alu_op_q, alu_op_d;
  logic [7:0]       rsp_result_q, rsp_result_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic [1:0]       rsp_err_q, rsp_err_d;

  logic [7:0] captured;

  function automatic logic op_legal(input logic [7:0] op);
    case (op)
      8'h00, 8'h01, 8'h02, 8'h03, 8'h13,
      8'h04, 8'h05, 8'h06,
      8'h08, 8'h09, 8'h0A, 8'h0B,
      8'h10, 8'h11: op_legal = 1'b1;
      default:      op_legal = 1'b0;
    endcase
  endfunction

  // Compare ops only define bits [1:0]; the upper bits from the ALU are discarded.
  always_comb begin
    captured = alu_result;
    if (alu_op_q == 8'h04 || alu_op_q == 8'h05 || alu_op_q == 8'h06)
      captured[7:2] = 6'd0;
  end

  always_comb begin
    // NOTE: every next-state variable gets a default first so no path infers a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    err_pend_d   = err_pend_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_result_d = rsp_result_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          rsp_tag_d = req_tag;
          state_d   = DRIVE;
          // Errors take one DRIVE edge so they answer with the same latency as SETTLE=1.
          cnt_d     = 4'd1;
          if (!op_legal(req_op)) begin
            err_pend_d = ERR_ILLEGAL;
          end else if ((req_op == 8'h03 || req_op == 8'h13) && req_b == 8'd0) begin
            err_pend_d = ERR_DIV0;
          end else begin
            err_pend_d = ERR_OK;
            alu_a_d    = req_a;
            alu_b_d    = req_b;
            alu_op_d   = req_op;
            cnt_d      = SETTLE_CNT;
          end
        end
      end
      DRIVE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          if (err_pend_q != ERR_OK) begin
            rsp_result_d = 8'd0;
            rsp_zero_d   = 1'b1;
            rsp_err_d    = err_pend_q;
          end else begin
            rsp_result_d = captured;
            rsp_zero_d   = (captured == 8'd0);
            rsp_err_d    = ERR_OK;
          end
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      err_pend_q   <= ERR_OK;
      alu_a_q      <= 8'd0;
      alu_b_q      <= 8'd0;
      alu_op_q     <= 8'd0;
      rsp_result_q <= 8'd0;
      rsp_tag_q    <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= ERR_OK;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      err_pend_q   <= err_pend_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_result_q <= rsp_result_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_result = rsp_result_q;
  assign rsp_tag    = rsp_tag_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench: three sequencers (SETTLE 1, 4, 8) each driving a bench ALU model,
// checked against an arithmetic reference model with directed and random transactions.
module tb_alu_sequencer;
  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst        [N];
  logic       req_valid  [N];
  logic       req_ready  [N];
  logic [7:0] req_op     [N];
  logic [7:0] req_a      [N];
  logic [7:0] req_b      [N];
  logic [3:0] req_tag    [N];
  logic [7:0] alu_a      [N];
  logic [7:0] alu_b      [N];
  logic [7:0] alu_op     [N];
  logic [7:0] alu_result [N];
  logic       rsp_valid  [N];
  logic       rsp_ready  [N];
  logic [7:0] rsp_result [N];
  logic [3:0] rsp_tag    [N];
  logic       rsp_zero   [N];
  logic [1:0] rsp_err    [N];

  int checks = 0;
  int errors = 0;

  logic [7:0] last_a  [N];
  logic [7:0] last_b  [N];
  logic [7:0] last_op [N];

  logic [7:0] legal_ops [14] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h13, 8'h04, 8'h05,
                                 8'h06, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h10, 8'h11};

  function automatic int settle_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 4 : 8);
  endfunction

  // Stand-in for the real ALU; compare ops return junk in bits [7:2].
  function automatic logic [7:0] alu_fn(input logic [7:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    case (op)
      8'h00:   alu_fn = a + b;
      8'h01:   alu_fn = a - b;
      8'h02:   alu_fn = a * b;
      8'h03:   alu_fn = (b != 0) ? a / b : 8'hFF;
      8'h13:   alu_fn = (b != 0) ? a % b : 8'hFF;
      8'h04:   alu_fn = 8'hFC | {7'd0, a == b};
      8'h05:   alu_fn = 8'hFC | {7'd0, a < b};
      8'h06:   alu_fn = 8'hFC | {7'd0, a > b};
      8'h08:   alu_fn = ~a;
      8'h09:   alu_fn = a & b;
      8'h0A:   alu_fn = a | b;
      8'h0B:   alu_fn = a ^ b;
      8'h10:   alu_fn = a << b[2:0];
      8'h11:   alu_fn = a >> b[2:0];
      default: alu_fn = 8'h5A;
    endcase
  endfunction

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_dut
      alu_sequencer #(.TAG_W(4), .SETTLE((g == 0) ? 1 : ((g == 1) ? 4 : 8))) u_dut (
        .clk        (clk),
        .rst        (rst[g]),
        .req_valid  (req_valid[g]),
        .req_ready  (req_ready[g]),
        .req_op     (req_op[g]),
        .req_a      (req_a[g]),
        .req_b      (req_b[g]),
        .req_tag    (req_tag[g]),
        .alu_a      (alu_a[g]),
        .alu_b      (alu_b[g]),
        .alu_op     (alu_op[g]),
        .alu_result (alu_result[g]),
        .rsp_valid  (rsp_valid[g]),
        .rsp_ready  (rsp_ready[g]),
        .rsp_result (rsp_result[g]),
        .rsp_tag    (rsp_tag[g]),
        .rsp_zero   (rsp_zero[g]),
        .rsp_err    (rsp_err[g])
      );
      assign alu_result[g] = alu_fn(alu_op[g], alu_a[g], alu_b[g]);
    end
  endgenerate

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected response computed with integer arithmetic from the opcode table.
  function automatic void model(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] res, output logic [1:0] err);
    int  ia = int'(a);
    int  ib = int'(b);
    int  r  = 0;
    bit  legal = 1'b0;
    foreach (legal_ops[i]) if (legal_ops[i] == op) legal = 1'b1;
    err = 2'd0;
    if (!legal) err = 2'd1;
    else if ((op == 8'h03 || op == 8'h13) && ib == 0) err = 2'd2;
    else begin
      case (op)
        8'h00: r = ia + ib;
        8'h01: r = ia - ib;
        8'h02: r = ia * ib;
        8'h03: r = ia / ib;
        8'h13: r = ia % ib;
        8'h04: r = (ia == ib) ? 1 : 0;
        8'h05: r = (ia < ib) ? 1 : 0;
        8'h06: r = (ia > ib) ? 1 : 0;
        8'h08: r = 255 - ia;
        8'h09: r = ia & ib;
        8'h0A: r = ia | ib;
        8'h0B: r = ia ^ ib;
        8'h10: r = ia * (1 << (ib % 8));
        8'h11: r = ia / (1 << (ib % 8));
        default: r = 0;
      endcase
    end
    res = (err != 2'd0) ? 8'd0 : 8'(r & 255);
  endfunction

  task automatic run_txn(input int d, input logic [7:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [3:0] tag, input int hold,
                         input bit pend);
    logic [7:0]  exp_res;
    logic [1:0]  exp_err;
    logic [23:0] exp_alu;
    logic [15:0] exp_rsp;
    int          lat;
    int          w;
    int          k;
    model(op, a, b, exp_res, exp_err);
    lat     = (exp_err == 2'd0) ? settle_of(d) : 1;
    exp_alu = (exp_err == 2'd0) ? {op, a, b} : {last_op[d], last_a[d], last_b[d]};
    exp_rsp = {1'b1, exp_res, tag, exp_res == 8'd0, exp_err};

    @(negedge clk);
    req_valid[d] = 1'b1;
    req_op[d]    = op;
    req_a[d]     = a;
    req_b[d]     = b;
    req_tag[d]   = tag;
    rsp_ready[d] = (hold == 0);
    w = 0;
    while (!req_ready[d] && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("accept_ready", 64'(req_ready[d]), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = pend;
    req_op[d]    = 8'($urandom);
    req_a[d]     = 8'($urandom);
    req_b[d]     = 8'($urandom);
    req_tag[d]   = 4'($urandom);

    k = 0;
    while (!rsp_valid[d] && k < 40) begin
      check("drive_alu", 64'({alu_op[d], alu_a[d], alu_b[d]}), 64'(exp_alu));
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    check("latency", 64'(k), 64'(lat));
    check("rsp", 64'({rsp_valid[d], rsp_result[d], rsp_tag[d], rsp_zero[d], rsp_err[d]}),
          64'(exp_rsp));

    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_hold", 64'({req_ready[d], rsp_valid[d], rsp_result[d], rsp_tag[d], rsp_zero[d],
                            rsp_err[d], alu_op[d], alu_a[d], alu_b[d]}),
            64'({1'b0, exp_rsp, exp_alu}));
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
    check("post_handshake", 64'({rsp_valid[d], req_ready[d]}), 64'(2'b01));
    if (exp_err == 2'd0) begin
      last_op[d] = op;
      last_a[d]  = a;
      last_b[d]  = b;
    end
  endtask

  initial begin
    for (int d = 0; d < N; d++) begin
      rst[d]       = 1'b1;
      req_valid[d] = 1'b0;
      req_op[d]    = 8'd0;
      req_a[d]     = 8'd0;
      req_b[d]     = 8'd0;
      req_tag[d]   = 4'd0;
      rsp_ready[d] = 1'b0;
      last_op[d]   = 8'd0;
      last_a[d]    = 8'd0;
      last_b[d]    = 8'd0;
    end
    #3;
    for (int d = 0; d < N; d++)
      check("reset_state", 64'({req_ready[d], rsp_valid[d], rsp_result[d], rsp_tag[d],
                                rsp_zero[d], rsp_err[d], alu_op[d], alu_a[d], alu_b[d]}),
            64'({2'b10, 39'd0}));
    @(negedge clk);
    for (int d = 0; d < N; d++) rst[d] = 1'b0;

    run_txn(0, 8'h00, 8'h7F, 8'h01, 4'd3, 0, 1'b0);
    run_txn(1, 8'h01, 8'h05, 8'h05, 4'd6, 0, 1'b0);
    run_txn(0, 8'h03, 8'h64, 8'h00, 4'd1, 0, 1'b0);
    run_txn(0, 8'h13, 8'h64, 8'h00, 4'd2, 0, 1'b0);
    run_txn(0, 8'h07, 8'h11, 8'h22, 4'd4, 0, 1'b0);
    run_txn(0, 8'h09, 8'hF0, 8'h3C, 4'd5, 0, 1'b0);
    run_txn(1, 8'h02, 8'h13, 8'h11, 4'd9, 5, 1'b1);
    run_txn(1, 8'h05, 8'h10, 8'h20, 4'd7, 0, 1'b0);

    // Reset in the middle of DRIVE on the SETTLE=8 instance.
    @(negedge clk);
    req_valid[2] = 1'b1;
    req_op[2]    = 8'h00;
    req_a[2]     = 8'h12;
    req_b[2]     = 8'h34;
    req_tag[2]   = 4'hA;
    rsp_ready[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[2] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst[2] = 1'b1;
    #1;
    check("mid_reset", 64'({req_ready[2], rsp_valid[2], rsp_result[2], rsp_tag[2], rsp_zero[2],
                            rsp_err[2], alu_op[2], alu_a[2], alu_b[2]}),
          64'({2'b10, 39'd0}));
    @(negedge clk);
    rst[2] = 1'b0;
    last_op[2] = 8'd0;
    last_a[2]  = 8'd0;
    last_b[2]  = 8'd0;
    begin
      int seen = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (rsp_valid[2]) seen++;
      end
      check("no_rsp_after_reset", 64'(seen), 64'd0);
    end
    run_txn(2, 8'h0B, 8'hA5, 8'h5A, 4'hC, 1, 1'b0);

    for (int t = 0; t < 45; t++) begin
      int         d;
      logic [7:0] op;
      logic [7:0] b;
      d  = int'($urandom_range(0, N - 1));
      op = ($urandom_range(0, 4) == 0) ? 8'($urandom) : legal_ops[$urandom_range(0, 13)];
      b  = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      run_txn(d, op, 8'($urandom), b, 4'($urandom), int'($urandom_range(0, 2)),
              1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
